// File: rtl/spi_word_pkg.sv
// Shared types and sizing helpers for the SPI word sender.
package spi_word_pkg;
  localparam int WORD_W   = 16;
  localparam int BITCNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  function automatic int div_cnt_w(input int div);
    return $clog2(div + 1);
  endfunction
endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles, restarted by clear.
module sclk_tick_gen
  import spi_word_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = div_cnt_w(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/spi_word_sender.sv
// Mode-0 SPI word serializer (MSB first, sclk idles low) with valid/ready input.
// Optional miso receive path enabled by defining SPI_WORD_RX_EN.
module spi_word_sender
  import spi_word_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tx_valid,
  input  logic [WORD_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              done
`ifdef SPI_WORD_RX_EN
  ,
  input  logic              miso,
  output logic [WORD_W-1:0] rx_data
`endif
);
  state_t state, state_nxt;
  logic tick, clear;
  logic accept, toggle, shift_en, finish;
  logic [BITCNT_W-1:0] bitcnt;
  // Bit 15 leaves on mosi at accept, so only the remaining 15 bits are held.
  logic [WORD_W-2:0] shift_reg;

  // Restarting the divider on every state change keeps sclk phase fixed per frame.
  assign clear = (state_nxt != state);

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (tx_valid) state_nxt = SETUP;
      SETUP: if (tick) state_nxt = SHIFT;
      SHIFT: if (tick && sclk && bitcnt == '0) state_nxt = HOLD;
      HOLD:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == IDLE);
    accept   = tx_ready && tx_valid;
    toggle   = (state == SHIFT) && tick;
    shift_en = toggle && sclk && (bitcnt != '0);
    finish   = (state == HOLD) && tick;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      cs_n   <= 1'b1;
      done   <= 1'b0;
      bitcnt <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        cs_n   <= 1'b0;
        mosi   <= tx_data[WORD_W-1];
        bitcnt <= BITCNT_W'(WORD_W - 1);
      end else if (finish) begin
        cs_n <= 1'b1;
      end
      if (toggle) begin
        sclk <= ~sclk;
      end
      if (shift_en) begin
        mosi   <= shift_reg[WORD_W-2];
        bitcnt <= bitcnt - BITCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shift_reg <= tx_data[WORD_W-2:0];
    end else if (shift_en) begin
      shift_reg <= {shift_reg[WORD_W-3:0], 1'b0};
    end
  end

`ifdef SPI_WORD_RX_EN
  logic [WORD_W-1:0] rx_shift;
  logic              rx_sample;

  // miso is captured on the edge that raises sclk.
  assign rx_sample = toggle && !sclk;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      if (rx_sample) begin
        rx_shift <= {rx_shift[WORD_W-2:0], miso};
      end
      if (finish) begin
        rx_data <= rx_shift;
      end
    end
  end
`endif
endmodule

// File: tb/tb_spi_word_sender.sv
// Scoreboard bench for spi_word_sender (CLK_DIV=2 main instance, CLK_DIV=1 second instance).
module tb_spi_word_sender;
  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        tx_valid, tx_ready, sclk, mosi, cs_n, done;
  logic [15:0] tx_data;
  logic        tx_valid1, tx_ready1, sclk1, mosi1, cs_n1, done1;
  logic [15:0] tx_data1;
`ifdef SPI_WORD_RX_EN
  logic [15:0] rx_data, rx_data1;
  logic [15:0] last_rx = '0;
`endif

  spi_word_sender #(.CLK_DIV(D)) dut (
    .clk(clk), .resetn(resetn), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .done(done)
`ifdef SPI_WORD_RX_EN
    , .miso(mosi), .rx_data(rx_data)
`endif
  );

  spi_word_sender #(.CLK_DIV(1)) dut1 (
    .clk(clk), .resetn(resetn), .tx_valid(tx_valid1), .tx_data(tx_data1),
    .tx_ready(tx_ready1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .done(done1)
`ifdef SPI_WORD_RX_EN
    , .miso(mosi1), .rx_data(rx_data1)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard for the CLK_DIV=2 instance
  int cyc = 0, lowcnt = 0, hicnt = 0, last_gap = 0, rises = 0, done_cnt = 0;
  int mosi_age = 0, since_rise = 1000;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
  logic [15:0] word = '0;
  logic [15:0] exp_q[$];
  int acc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      exp_q.delete();
      acc_q.delete();
      word = '0; rises = 0; lowcnt = 0; hicnt = 0;
      prev_sclk = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
      mosi_age = 0; since_rise = 1000;
`ifdef SPI_WORD_RX_EN
      last_rx = '0;
`endif
    end else begin
      since_rise++;
      if (mosi !== prev_mosi) begin
        mosi_age = 1;
        chk("mosi_hold", 32'(since_rise >= D), 32'd1);
      end else begin
        mosi_age++;
      end
      if (sclk && !prev_sclk) begin
        chk("mosi_setup", 32'(mosi_age > D), 32'd1);
        word = {word[14:0], mosi};
        rises++;
        since_rise = 0;
      end
      if (!cs_n) lowcnt++;
      if (cs_n) hicnt++;
      else if (prev_cs) begin
        last_gap = hicnt;
        hicnt = 0;
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          logic [15:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("word", 32'(word), 32'(e));
          chk("rises", rises, 32'd16);
          chk("cs_low", lowcnt, 34 * D);
          chk("done_lat", cyc - a, 34 * D + 1);
`ifdef SPI_WORD_RX_EN
          chk("rx_data", 32'(rx_data), 32'(e));
          last_rx = e;
`endif
        end
        word = '0; rises = 0; lowcnt = 0;
      end
      if (tx_valid && tx_ready) begin
        exp_q.push_back(tx_data);
        acc_q.push_back(cyc);
`ifdef SPI_WORD_RX_EN
        chk("rx_hold", 32'(rx_data), 32'(last_rx));
`endif
      end
      prev_sclk = sclk;
      prev_cs = cs_n;
      prev_mosi = mosi;
    end
  end

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data = w;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  initial begin
    int n, d0, tog, first_r, last_f;
    logic p, got;
    logic [15:0] w1;

    resetn = 1'b1;
    tx_valid = 1'b0; tx_data = '0;
    tx_valid1 = 1'b0; tx_data1 = '0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cs_n1", 32'(cs_n1), 32'd1);
`ifdef SPI_WORD_RX_EN
    chk("rst_rx", 32'(rx_data), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Basic frame
    send(16'hA5C3);
    wait_done(1);

    // Busy rejection: valid held with 0x1111 during a 0xFFFF frame
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data = 16'hFFFF;
    @(negedge clk);
    chk("busy_first_ready", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    tx_data = 16'h1111;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("busy_acc_in_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_done(3);
    chk("cs_gap", last_gap, 32'd1);

    // CLK_DIV=1 instance
    @(posedge clk); #1;
    tx_valid1 = 1'b1;
    tx_data1 = 16'h8001;
    @(negedge clk);
    chk("div1_ready", 32'(tx_ready1), 32'd1);
    @(posedge clk); #1;
    tx_valid1 = 1'b0;
    p = 1'b0; tog = 0; first_r = -1; last_f = 0; w1 = '0; got = 1'b0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (sclk1 !== p) begin
        tog++;
        if (sclk1) begin
          if (first_r < 0) first_r = k;
          w1 = {w1[14:0], mosi1};
        end else begin
          last_f = k;
        end
      end
      p = sclk1;
      if (done1) begin
        got = 1'b1;
        chk("div1_done_lat", k, 32'd35);
      end
    end
    if (!got) chk("div1_done_timeout", 32'd0, 32'd1);
    chk("div1_word", 32'(w1), 32'h8001);
    chk("div1_toggles", tog, 32'd32);
    chk("div1_span", last_f - first_r, 32'd31);
`ifdef SPI_WORD_RX_EN
    chk("div1_rx", 32'(rx_data1), 32'h8001);
`endif

    // Reset mid-frame after the 5th sclk rise
    d0 = done_cnt;
    send(16'h5A5A);
    n = 0;
    while (rises < 5 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("rise5", rises, 32'd5);
    #2 resetn = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_ready", 32'(tx_ready), 32'd1);
`ifdef SPI_WORD_RX_EN
    chk("abort_rx", 32'(rx_data), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) @(posedge clk);
    chk("abort_no_done", done_cnt, d0);
    send(16'h00FF);
    wait_done(d0 + 1);
    chk("after_abort_frames", done_cnt, d0 + 1);

`ifdef SPI_WORD_RX_EN
    // Loopback (miso tied to mosi)
    send(16'h1234);
    wait_done(d0 + 2);
    send(16'hBEEF);
    wait_done(d0 + 3);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
